pc_call_stack: RTL and testbench

//   Parametrised program counter with a LIFO return-address stack, for the next-gen Miyamii fetch unit.

---
 rtl/miyamii_pkg.sv | 16 +
 rtl/pc_lifo.sv | 55 +++++
 rtl/pc_call_stack.sv | 98 +++++++++
 tb/tb_pc_call_stack.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/miyamii_pkg.sv
// Shared types and limits for the Miyamii fetch-unit program counter.
package miyamii_pkg;

  typedef enum logic [2:0] {
    OpNop  = 3'd0,
    OpInc  = 3'd1,
    OpJump = 3'd2,
    OpCall = 3'd3,
    OpRet  = 3'd4,
    OpInt  = 3'd5
  } pc_op_t;

  localparam int unsigned PC_W_DEFAULT = 12;
  localparam int unsigned DEPTH_MAX    = 8;

endpackage

// File: rtl/pc_lifo.sv
// Return-address LIFO with a ring write pointer; optionally overwrites the oldest entry when full.
module pc_lifo
  import miyamii_pkg::*;
#(
  parameter int unsigned W     = PC_W_DEFAULT,
  parameter int unsigned DEPTH = 3,
  parameter bit          WRAP  = 1'b0,
  localparam int unsigned LvlW = $clog2(DEPTH + 1),
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [W-1:0]    push_data,
  output logic            push_ok,
  output logic            pop_ok,
  output logic [W-1:0]    tos,
  output logic [LvlW-1:0] level,
  output logic            full,
  output logic            empty
);

  logic [W-1:0]    mem_q [DEPTH];
  logic [PtrW-1:0] wp_q, wp_inc, wp_dec;
  logic [LvlW-1:0] level_q;

  assign wp_inc  = (wp_q == PtrW'(DEPTH - 1)) ? '0 : wp_q + PtrW'(1);
  assign wp_dec  = (wp_q == '0) ? PtrW'(DEPTH - 1) : wp_q - PtrW'(1);

  assign full    = (level_q == LvlW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign tos     = empty ? '0 : mem_q[wp_dec];

  assign push_ok = push && (!full || WRAP);
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wp_q    <= '0;
      level_q <= '0;
    end else if (push_ok) begin
      mem_q[wp_q] <= push_data;
      wp_q        <= wp_inc;
      // A wrap-mode overwrite replaces the oldest entry, so the count saturates.
      if (!full) level_q <= level_q + LvlW'(1);
    end else if (pop_ok) begin
      wp_q    <= wp_dec;
      level_q <= level_q - LvlW'(1);
    end
  end

endmodule

// File: rtl/pc_call_stack.sv
// Program counter with return-address stack: decodes one control op per cycle and keeps fault flags.
module pc_call_stack
  import miyamii_pkg::*;
#(
  parameter int unsigned    PC_W     = PC_W_DEFAULT,
  parameter int unsigned    DEPTH    = 3,
  parameter bit             OVF_WRAP = 1'b0,
  parameter logic [PC_W-1:0] RST_VEC = '0,
  parameter logic [PC_W-1:0] INT_VEC = PC_W'('h004),
  localparam int unsigned   LvlW     = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic [2:0]      op,
  input  logic [PC_W-1:0] target,
  input  logic            err_clr,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] tos,
  output logic [LvlW-1:0] level,
  output logic            full,
  output logic            empty,
  output logic            ovf_err,
  output logic            unf_err
);

  logic [PC_W-1:0] pc_q, pc_d, pc_inc, ret_addr;
  logic            push, pop, push_ok, pop_ok;
  logic            ovf_set, unf_set;
  logic            ovf_q, unf_q;

  assign pc_inc   = pc_q + PC_W'(1);
  // INT returns to the interrupted instruction so it is re-executed.
  assign ret_addr = (op == OpInt) ? pc_q : pc_inc;

  pc_lifo #(
    .W     (PC_W),
    .DEPTH (DEPTH),
    .WRAP  (OVF_WRAP)
  ) u_lifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (ret_addr),
    .push_ok   (push_ok),
    .pop_ok    (pop_ok),
    .tos       (tos),
    .level     (level),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    pc_d    = pc_q;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (!stall) begin
      case (op)
        OpInc:  pc_d = pc_inc;
        OpJump: pc_d = target;
        OpCall, OpInt: begin
          push    = 1'b1;
          ovf_set = !push_ok;
          if (!push_ok)          pc_d = pc_inc;
          else if (op == OpCall) pc_d = target;
          else                   pc_d = INT_VEC;
        end
        OpRet: begin
          pop     = 1'b1;
          unf_set = !pop_ok;
          pc_d    = pop_ok ? tos : pc_inc;
        end
        default: pc_d = pc_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RST_VEC;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      // A new fault outranks a simultaneous clear.
      ovf_q <= ovf_set | (ovf_q & ~err_clr);
      unf_q <= unf_set | (unf_q & ~err_clr);
    end
  end

  assign pc      = pc_q;
  assign ovf_err = ovf_q;
  assign unf_err = unf_q;

endmodule

// File: tb/tb_pc_call_stack.sv
// Drives reject-mode and wrap-mode instances with identical stimulus and scoreboards both.
module tb_pc_call_stack;

  localparam int PC_W  = 12;
  localparam int DEPTH = 3;
  localparam int MASK  = (1 << PC_W) - 1;
  localparam logic [PC_W-1:0] RST_V = 12'h000;
  localparam logic [PC_W-1:0] INT_V = 12'h004;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] tos;
    logic [1:0]      level;
    logic            full;
    logic            empty;
    logic            ovf;
    logic            unf;
  } obs_t;

  logic            clk = 1'b0;
  logic            rst, stall, err_clr;
  logic [2:0]      op;
  logic [PC_W-1:0] target;

  logic [PC_W-1:0] pc0, tos0, pc1, tos1;
  logic [1:0]      lvl0, lvl1;
  logic            full0, empty0, ovf0, unf0, full1, empty1, ovf1, unf1;

  always #5 clk = ~clk;

  pc_call_stack #(.PC_W(PC_W), .DEPTH(DEPTH), .OVF_WRAP(1'b0), .RST_VEC(RST_V), .INT_VEC(INT_V))
  u_rej (
    .clk(clk), .rst(rst), .stall(stall), .op(op), .target(target), .err_clr(err_clr),
    .pc(pc0), .tos(tos0), .level(lvl0), .full(full0), .empty(empty0),
    .ovf_err(ovf0), .unf_err(unf0)
  );

  pc_call_stack #(.PC_W(PC_W), .DEPTH(DEPTH), .OVF_WRAP(1'b1), .RST_VEC(RST_V), .INT_VEC(INT_V))
  u_wrap (
    .clk(clk), .rst(rst), .stall(stall), .op(op), .target(target), .err_clr(err_clr),
    .pc(pc1), .tos(tos1), .level(lvl1), .full(full1), .empty(empty1),
    .ovf_err(ovf1), .unf_err(unf1)
  );

  // Reference model: stack as an array ordered oldest..newest, index 0 oldest.
  int m_pc [2];
  int m_stk[2][DEPTH];
  int m_cnt[2];
  bit m_ovf[2];
  bit m_unf[2];

  obs_t exp_q0[$];
  obs_t exp_q1[$];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic obs_t model_obs(int w);
    obs_t o;
    o.pc    = PC_W'(m_pc[w]);
    o.tos   = (m_cnt[w] > 0) ? PC_W'(m_stk[w][m_cnt[w] - 1]) : '0;
    o.level = 2'(m_cnt[w]);
    o.full  = (m_cnt[w] == DEPTH);
    o.empty = (m_cnt[w] == 0);
    o.ovf   = m_ovf[w];
    o.unf   = m_unf[w];
    return o;
  endfunction

  task automatic model_step(int w, bit r, bit s, int o, int tgt, bit clr);
    bit oset = 0;
    bit uset = 0;
    int ret, dest;
    if (r) begin
      m_pc[w] = int'(RST_V); m_cnt[w] = 0; m_ovf[w] = 0; m_unf[w] = 0;
      return;
    end
    if (!s) begin
      case (o)
        1: m_pc[w] = (m_pc[w] + 1) & MASK;
        2: m_pc[w] = tgt;
        3, 5: begin
          ret  = (o == 3) ? ((m_pc[w] + 1) & MASK) : m_pc[w];
          dest = (o == 3) ? tgt : int'(INT_V);
          if (m_cnt[w] < DEPTH) begin
            m_stk[w][m_cnt[w]] = ret; m_cnt[w]++; m_pc[w] = dest;
          end else if (w == 1) begin
            for (int i = 0; i < DEPTH - 1; i++) m_stk[w][i] = m_stk[w][i + 1];
            m_stk[w][DEPTH - 1] = ret; m_pc[w] = dest;
          end else begin
            m_pc[w] = (m_pc[w] + 1) & MASK; oset = 1;
          end
        end
        4: begin
          if (m_cnt[w] == 0) begin
            m_pc[w] = (m_pc[w] + 1) & MASK; uset = 1;
          end else begin
            m_cnt[w]--; m_pc[w] = m_stk[w][m_cnt[w]];
          end
        end
        default: ;
      endcase
    end
    m_ovf[w] = oset | (m_ovf[w] & !clr);
    m_unf[w] = uset | (m_unf[w] & !clr);
  endtask

  task automatic step(bit r, bit s, int o, int tgt, bit clr);
    @(negedge clk);
    rst = r; stall = s; op = 3'(o); target = PC_W'(tgt); err_clr = clr;
    model_step(0, r, s, o, tgt, clr);
    model_step(1, r, s, o, tgt, clr);
    exp_q0.push_back(model_obs(0));
    exp_q1.push_back(model_obs(1));
  endtask

  task automatic check(string name, obs_t got, obs_t exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got pc=%h tos=%h lvl=%0d full=%b empty=%b ovf=%b unf=%b, want pc=%h tos=%h lvl=%0d full=%b empty=%b ovf=%b unf=%b",
                  name, got.pc, got.tos, got.level, got.full, got.empty, got.ovf, got.unf,
                  exp.pc, exp.tos, exp.level, exp.full, exp.empty, exp.ovf, exp.unf);
  endtask

  // Monitor: every cycle the DUTs present state; compare against the oldest pending expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q0.size() > 0) check("reject", {pc0, tos0, lvl0, full0, empty0, ovf0, unf0}, exp_q0.pop_front());
      if (exp_q1.size() > 0) check("wrap", {pc1, tos1, lvl1, full1, empty1, ovf1, unf1}, exp_q1.pop_front());
    end
  end

  initial begin
    rst = 1'b1; stall = 1'b0; op = 3'd0; target = '0; err_clr = 1'b0;
    // Reset then INC sequence.
    step(1, 0, 0, 0, 0);
    repeat (4) step(0, 0, 1, 0, 0);
    // Nested call/return.
    step(0, 0, 2, 'h010, 0);
    step(0, 0, 3, 'h200, 0);
    step(0, 0, 3, 'h300, 0);
    step(0, 0, 4, 0, 0);
    step(0, 0, 4, 0, 0);
    // Fill, then overflow at 0x050, then clear.
    step(0, 0, 3, 'h100, 0);
    step(0, 0, 3, 'h200, 0);
    step(0, 0, 3, 'h300, 0);
    step(0, 0, 2, 'h050, 0);
    step(0, 0, 3, 'h7FF, 0);
    step(0, 0, 0, 0, 1);
    // Overwrite sequence then drain past empty.
    step(1, 0, 0, 0, 0);
    step(0, 0, 2, 'h001, 0);
    step(0, 0, 3, 'h101, 0);
    step(0, 0, 3, 'h201, 0);
    step(0, 0, 3, 'h301, 0);
    step(0, 0, 3, 'h400, 0);
    repeat (4) step(0, 0, 4, 0, 0);
    // Return-address wrap and INT.
    step(1, 0, 0, 0, 0);
    step(0, 0, 2, 'hFFF, 0);
    step(0, 0, 3, 'h100, 0);
    step(0, 0, 2, 'h123, 0);
    step(0, 0, 5, 0, 0);
    step(0, 0, 4, 0, 0);
    // Stall, mid-sequence reset, underflow racing a clear; opcodes 6/7 act as NOP.
    step(0, 0, 3, 'h222, 0);
    repeat (3) step(0, 1, 3, 'h333, 0);
    step(0, 0, 6, 0, 0);
    step(0, 0, 7, 0, 0);
    step(1, 0, 3, 'h444, 0);
    step(0, 0, 4, 0, 1);
    step(0, 1, 0, 0, 1);
    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
           int'($urandom_range(0, 7)), int'($urandom_range(0, MASK)),
           ($urandom_range(0, 7) == 0));
    end
    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && (exp_q0.size() > 0 || exp_q1.size() > 0); i++) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q0.size() == 0 && exp_q1.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d/%0d pending, want 0/0", exp_q0.size(), exp_q1.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
